// File: rtl/seg_scan_ctrl.sv
// Memory-mapped multiplexed 7-segment controller: per-digit hex/raw registers, scanned one digit per CLK_DIV cycles.
// Outputs are registered, so a register write or a scan advance is visible one edge later.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int CLK_DIV    = 50000,
   parameter bit ACTIVE_LOW = 1'b1,
   parameter int ADDR_W     = $clog2(NUM_DIGITS + 1)
) (
   input  logic                  sysclk,
   input  logic                  Reset_n,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [8:0]            wr_data,
   output logic [8:0]            rd_data,
   output logic [NUM_DIGITS-1:0] digi_sel,
   output logic [6:0]            digi_seg,
   output logic                  scan_tick
);
   localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] SEL_OFF  = {NUM_DIGITS{ACTIVE_LOW}};
   localparam logic [6:0]            SEG_OFF  = {7{ACTIVE_LOW}};

   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   logic [8:0]            digit_q [NUM_DIGITS];
   logic [8:0]            digit_d [NUM_DIGITS];
   logic                  en_q, en_d;
   logic [PRE_W-1:0]      pre_q, pre_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  tick_q, tick_d;
   logic [NUM_DIGITS-1:0] sel_q, sel_d, sel_on;
   logic [6:0]            seg_q, seg_d, seg_on;
   logic [8:0]            cur;
   logic                  wrap;

   always_comb begin
      digit_d = digit_q;
      en_d    = en_q;
      if (wr_en) begin
         for (int i = 0; i < NUM_DIGITS; i++)
            if (addr == ADDR_W'(i)) digit_d[i] = wr_data;
         if (addr == ADDR_W'(NUM_DIGITS)) en_d = wr_data[0];
      end

      wrap   = (pre_q == PRE_LAST);
      pre_d  = wrap ? '0 : pre_q + PRE_W'(1);
      idx_d  = idx_q;
      if (wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      tick_d = wrap;

      // Display samples the pre-edge index and registers, giving the one-edge output lag.
      cur    = '0;
      sel_on = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur       = digit_q[i];
            sel_on[i] = 1'b1;
         end
      end
      seg_on = cur[8] ? cur[6:0] : hex7(cur[3:0]);

      if (en_q) begin
         sel_d = sel_on ^ SEL_OFF;
         seg_d = seg_on ^ SEG_OFF;
      end else begin
         sel_d = SEL_OFF;
         seg_d = SEG_OFF;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (addr == ADDR_W'(i)) rd_data = digit_q[i];
      if (addr == ADDR_W'(NUM_DIGITS)) rd_data = {8'b0, en_q};
   end

   always_ff @(posedge sysclk) begin
      if (!Reset_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
         en_q   <= 1'b0;
         pre_q  <= '0;
         idx_q  <= '0;
         tick_q <= 1'b0;
         sel_q  <= SEL_OFF;
         seg_q  <= SEG_OFF;
      end else begin
         digit_q <= digit_d;
         en_q    <= en_d;
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         tick_q  <= tick_d;
         sel_q   <= sel_d;
         seg_q   <= seg_d;
      end
   end

   assign digi_sel  = sel_q;
   assign digi_seg  = seg_q;
   assign scan_tick = tick_q;
endmodule
